// File: rtl/read_queue_manager_if.sv
// Descriptor enqueue, read-request and address-issue signals shared between
// the write path, the read arbiter and read_queue_manager.
interface read_queue_manager_if #(
  parameter int unsigned num_of_priorities = 8,
  parameter int unsigned address_width     = 12,
  parameter int unsigned len_width         = 6
);
  localparam int unsigned pw = (num_of_priorities > 1) ? $clog2(num_of_priorities) : 1;

  logic                         enq_vld;
  logic [pw-1:0]                enq_priority;
  logic [address_width-1:0]     enq_addr;
  logic [len_width-1:0]         enq_len;
  logic [num_of_priorities-1:0] queue_full;
  logic [num_of_priorities-1:0] prepared;
  logic [num_of_priorities-1:0] next_data;
  logic [address_width-1:0]     address_to_read;
  logic                         addr_vld;
  logic                         last;
  logic                         pkt_done;
  logic [pw-1:0]                done_priority;
  logic                         err;

  modport master (
    output enq_vld, enq_priority, enq_addr, enq_len, next_data,
    input  queue_full, prepared, address_to_read, addr_vld, last,
           pkt_done, done_priority, err
  );

  modport slave (
    input  enq_vld, enq_priority, enq_addr, enq_len, next_data,
    output queue_full, prepared, address_to_read, addr_vld, last,
           pkt_done, done_priority, err
  );
endinterface

// File: rtl/read_queue_manager.sv
// Per-priority {addr,len} descriptor FIFOs feeding the read arbiter; issues one
// SRAM word address per request and pops the head descriptor on its last word.
module read_queue_manager #(
  parameter int unsigned num_of_priorities = 8,
  parameter int unsigned address_width     = 12,
  parameter int unsigned len_width         = 6,
  parameter int unsigned queue_depth       = 8
) (
  input logic             clk,
  input logic             rst,
  read_queue_manager_if.slave bus
);
  localparam int unsigned pw = (num_of_priorities > 1) ? $clog2(num_of_priorities) : 1;
  localparam int unsigned qw = $clog2(queue_depth);

  typedef logic [qw:0] ptr_t;

  logic [address_width-1:0] addr_mem [num_of_priorities][queue_depth];
  logic [len_width-1:0]     len_mem  [num_of_priorities][queue_depth];
  ptr_t                     rd_ptr   [num_of_priorities];
  ptr_t                     wr_ptr   [num_of_priorities];
  ptr_t                     rd_nxt   [num_of_priorities];
  ptr_t                     wr_nxt   [num_of_priorities];
  logic [len_width-1:0]     cnt      [num_of_priorities];

  logic [pw-1:0]            sel;
  logic                     found;
  logic                     multi;
  logic                     enq_ok;
  logic                     serve;
  logic                     is_last;
  logic [address_width-1:0] head_addr;
  logic [len_width-1:0]     head_len;

  // Lowest set request bit wins; the rest only contribute to err.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < num_of_priorities; i++) begin
      if (bus.next_data[i] && !found) begin
        sel   = pw'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    multi     = (bus.next_data & (bus.next_data - num_of_priorities'(1))) != '0;
    enq_ok    = bus.enq_vld && !bus.queue_full[bus.enq_priority] && (bus.enq_len != '0);
    serve     = found && bus.prepared[sel];
    head_addr = addr_mem[sel][rd_ptr[sel][qw-1:0]];
    head_len  = len_mem[sel][rd_ptr[sel][qw-1:0]];
    is_last   = (cnt[sel] == head_len - len_width'(1));
  end

  always_comb begin
    for (int unsigned p = 0; p < num_of_priorities; p++) begin
      wr_nxt[p] = wr_ptr[p];
      rd_nxt[p] = rd_ptr[p];
      if (enq_ok && (bus.enq_priority == pw'(p)))
        wr_nxt[p] = wr_ptr[p] + ptr_t'(1);
      if (serve && is_last && (sel == pw'(p)))
        rd_nxt[p] = rd_ptr[p] + ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) begin
      addr_mem[bus.enq_priority][wr_ptr[bus.enq_priority][qw-1:0]] <= bus.enq_addr;
      len_mem[bus.enq_priority][wr_ptr[bus.enq_priority][qw-1:0]]  <= bus.enq_len;
    end
  end

  // Status flags are registered from the next-pointer values, so a pop that
  // empties a queue clears prepared in the same cycle as pkt_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned p = 0; p < num_of_priorities; p++) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        cnt[p]    <= '0;
      end
      bus.queue_full      <= '0;
      bus.prepared        <= '0;
      bus.address_to_read <= '0;
      bus.addr_vld        <= 1'b0;
      bus.last            <= 1'b0;
      bus.pkt_done        <= 1'b0;
      bus.done_priority   <= '0;
      bus.err             <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < num_of_priorities; p++) begin
        rd_ptr[p]          <= rd_nxt[p];
        wr_ptr[p]          <= wr_nxt[p];
        bus.queue_full[p]  <= (wr_nxt[p] == {~rd_nxt[p][qw], rd_nxt[p][qw-1:0]});
        bus.prepared[p]    <= (wr_nxt[p] != rd_nxt[p]);
      end
      if (serve) begin
        cnt[sel]            <= is_last ? '0 : cnt[sel] + len_width'(1);
        bus.address_to_read <= head_addr + address_width'(cnt[sel]);
      end
      if (serve && is_last)
        bus.done_priority <= sel;
      bus.addr_vld <= serve;
      bus.last     <= serve && is_last;
      bus.pkt_done <= serve && is_last;
      bus.err      <= (bus.enq_vld && !enq_ok) || (found && (multi || !bus.prepared[sel]));
    end
  end
endmodule

// File: tb/tb_read_queue_manager.sv
// Scoreboard bench for read_queue_manager: directed scenarios plus random
// traffic checked against a queue-based descriptor model.
module tb_read_queue_manager;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   checking = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  read_queue_manager_if #(.num_of_priorities(8), .address_width(12), .len_width(6)) bus ();

  read_queue_manager #(
    .num_of_priorities(8), .address_width(12), .len_width(6), .queue_depth(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         due;
    logic       vld;
    logic [11:0] addr;
    logic       last;
    logic       done;
    logic [2:0] dp;
    logic       err;
    logic [7:0] prep;
    logic [7:0] full;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int unsigned mq_addr[8][$];
  int unsigned mq_len [8][$];
  int unsigned moff   [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        me = sb.pop_front();
        check("addr_vld", 32'(bus.addr_vld), 32'(me.vld));
        check("last", 32'(bus.last), 32'(me.last));
        check("pkt_done", 32'(bus.pkt_done), 32'(me.done));
        check("err", 32'(bus.err), 32'(me.err));
        check("prepared", 32'(bus.prepared), 32'(me.prep));
        check("queue_full", 32'(bus.queue_full), 32'(me.full));
        if (me.vld) check("address_to_read", 32'(bus.address_to_read), 32'(me.addr));
        if (me.done) check("done_priority", 32'(bus.done_priority), 32'(me.dp));
      end
    end
  end

  task automatic set_idle();
    bus.enq_vld      = 1'b0;
    bus.enq_priority = '0;
    bus.enq_addr     = '0;
    bus.enq_len      = '0;
    bus.next_data    = '0;
  endtask

  task automatic model_clear();
    for (int p = 0; p < 8; p++) begin
      mq_addr[p].delete();
      mq_len[p].delete();
      moff[p] = 0;
    end
  endtask

  // Drive one cycle of stimulus and push the outcome the model predicts.
  task automatic step(input bit ev, input int unsigned pri, input int unsigned a,
                      input int unsigned l, input logic [7:0] nd);
    exp_t e;
    int   s;
    bit   acc;
    e = '{default: '0};
    bus.enq_vld      = ev;
    bus.enq_priority = 3'(pri);
    bus.enq_addr     = 12'(a);
    bus.enq_len      = 6'(l);
    bus.next_data    = nd;
    e.due = cyc + 1;
    acc = ev && (mq_addr[pri].size() < 8) && (l != 0);
    if (ev && !acc) e.err = 1'b1;
    s = -1;
    for (int i = 0; i < 8; i++) if (nd[i] && s < 0) s = i;
    if (s >= 0) begin
      if ($countones(nd) > 1) e.err = 1'b1;
      if (mq_addr[s].size() == 0) e.err = 1'b1;
      else begin
        e.vld  = 1'b1;
        e.addr = 12'((mq_addr[s][0] + moff[s]) % 4096);
        e.last = (moff[s] == mq_len[s][0] - 1);
        if (e.last) begin
          void'(mq_addr[s].pop_front());
          void'(mq_len[s].pop_front());
          moff[s] = 0;
          e.done  = 1'b1;
          e.dp    = 3'(s);
        end else begin
          moff[s]++;
        end
      end
    end
    if (acc) begin
      mq_addr[pri].push_back(a);
      mq_len[pri].push_back(l);
    end
    for (int p = 0; p < 8; p++) begin
      e.prep[p] = (mq_addr[p].size() != 0);
      e.full[p] = (mq_addr[p].size() == 8);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_queue_full"}, 32'(bus.queue_full), 32'h0);
    check({tag, "_prepared"}, 32'(bus.prepared), 32'h0);
    check({tag, "_address_to_read"}, 32'(bus.address_to_read), 32'h0);
    check({tag, "_addr_vld"}, 32'(bus.addr_vld), 32'h0);
    check({tag, "_last"}, 32'(bus.last), 32'h0);
    check({tag, "_pkt_done"}, 32'(bus.pkt_done), 32'h0);
    check({tag, "_done_priority"}, 32'(bus.done_priority), 32'h0);
    check({tag, "_err"}, 32'(bus.err), 32'h0);
  endtask

  initial begin
    int          r;
    int          pick;
    int          cands[$];
    logic [7:0]  nd;
    int unsigned ln;

    set_idle();
    model_clear();
    #1 rst = 1'b0;
    #10 check_all_zero("reset");
    #11 rst = 1'b1;
    @(posedge clk);
    #1 checking = 1'b1;

    // Three-word packet on p2
    step(1, 2, 'h010, 3, 8'h00);
    repeat (3) step(0, 0, 0, 0, 8'h04);
    // Address wraps past the top of SRAM
    step(1, 0, 'hFFE, 4, 8'h00);
    repeat (4) step(0, 0, 0, 0, 8'h01);
    // Fill p5, overflow, then enqueue while popping the full queue
    for (int i = 0; i < 8; i++) step(1, 5, 'h200 + i, 1, 8'h00);
    step(1, 5, 'h300, 1, 8'h00);
    step(1, 5, 'h301, 1, 8'h20);
    repeat (8) step(0, 0, 0, 0, 8'h20);
    // Empty-queue request and multi-hot request
    step(0, 0, 0, 0, 8'h80);
    step(1, 1, 'h040, 2, 8'h00);
    step(0, 0, 0, 0, 8'h06);
    step(0, 0, 0, 0, 8'h02);
    // Switching priority mid-packet and resuming
    step(1, 1, 'h080, 4, 8'h00);
    step(1, 3, 'h0C0, 2, 8'h00);
    step(0, 0, 0, 0, 8'h02);
    step(0, 0, 0, 0, 8'h02);
    step(0, 0, 0, 0, 8'h08);
    step(0, 0, 0, 0, 8'h08);
    step(0, 0, 0, 0, 8'h02);
    step(0, 0, 0, 0, 8'h02);
    // Zero-length enqueue is rejected
    step(1, 6, 'h123, 0, 8'h00);

    for (int n = 0; n < 1500; n++) begin
      ln = ($urandom % 8 == 0) ? ($urandom % 64) : (1 + $urandom % 4);
      r = $urandom % 10;
      cands.delete();
      for (int p = 0; p < 8; p++) if (mq_addr[p].size() != 0) cands.push_back(p);
      nd = 8'h00;
      if (r < 6) begin
        pick = (cands.size() != 0) ? cands[$urandom % cands.size()] : $urandom % 8;
        nd[pick] = 1'b1;
      end else if (r == 7) begin
        nd[$urandom % 8] = 1'b1;
      end else if (r == 8) begin
        nd = 8'($urandom);
      end
      step($urandom % 2 == 0, $urandom % 8, $urandom % 4096, ln, nd);
    end

    // Asynchronous reset in the middle of a packet
    step(1, 4, 'h100, 10, 8'h00);
    repeat (3) step(0, 0, 0, 0, 8'h10);
    set_idle();
    @(negedge clk);
    #1 checking = 1'b0;
    rst = 1'b0;
    #1 check_all_zero("midreset");
    sb.delete();
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 checking = 1'b1;
    check("post_reset_prepared", 32'(bus.prepared), 32'h0);
    step(0, 0, 0, 0, 8'h10);
    step(1, 4, 'h500, 2, 8'h00);
    repeat (2) step(0, 0, 0, 0, 8'h10);

    set_idle();
    @(negedge clk);
    #1 check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
